// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, RS levels and default timing for the LCD read engine
package lcd_pkg;
    typedef enum logic [2:0] {IDLE, CMD_WR, CMD_HOLD, RD_LOW, RD_HIGH, RSP_WAIT} lcd_state_t;
    localparam logic LCD_CMD_INST = 1'b0;
    localparam logic LCD_CMD_DATA = 1'b1;
    localparam int LCD_T_WRL = 2;
    localparam int LCD_T_WRH = 2;
    localparam int LCD_T_RDL = 12;
    localparam int LCD_T_RDH = 4;
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = c > m ? c : m;
        return d > m ? d : m;
    endfunction
endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter; done marks the last cycle of the current phase
module lcd_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else cnt <= load ? value : cnt - 1'b1;
    assign done = cnt == '0;
endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: 8080-style LCD register read (one command write, then req_len+1 strobed reads)
// LCD_RD_DUMMY_EN: discard the first read strobe after the command phase
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_WRL = LCD_T_WRL,
    parameter int T_WRH = LCD_T_WRH,
    parameter int T_RDL = LCD_T_RDL,
    parameter int T_RDH = LCD_T_RDH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_cmd,
    input  logic [3:0]  req_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic        lcd_hw_cs,
    output logic        lcd_hw_rs,
    output logic        lcd_hw_wr,
    output logic        lcd_hw_rd,
    output logic [15:0] lcd_hw_data_o,
    output logic        lcd_hw_data_oe,
    input  logic [15:0] lcd_hw_data_i
);
    localparam int W = $clog2(max4(T_WRL, T_WRH, T_RDL, T_RDH) + 1);
`ifdef LCD_RD_DUMMY_EN
    localparam logic DUMMY = 1'b1;
`else
    localparam logic DUMMY = 1'b0;
`endif
    lcd_state_t state;
    logic [3:0] cnt;
    logic dummy, load, done;
    logic [W-1:0] value;

    // the timer is always preloaded with the length of the phase that follows the current one
    assign load  = done || state == IDLE || state == RSP_WAIT;
    assign value = state == IDLE ? W'(T_WRL - 1) :
                   state == CMD_WR ? W'(T_WRH - 1) :
                   state == RD_LOW ? W'(T_RDH - 1) : W'(T_RDL - 1);
    assign req_ready = resetn && state == IDLE;
    assign busy = state != IDLE;

    lcd_phase_timer #(.W(W)) u_timer (
        .clk(clk), .resetn(resetn), .load(load), .value(value), .done(done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            lcd_hw_cs      <= 1'b1;
            lcd_hw_rs      <= LCD_CMD_DATA;
            lcd_hw_wr      <= 1'b1;
            lcd_hw_rd      <= 1'b1;
            lcd_hw_data_oe <= 1'b0;
            lcd_hw_data_o  <= '0;
            rsp_valid      <= 1'b0;
            rsp_last       <= 1'b0;
            rsp_data       <= '0;
            cnt            <= '0;
            dummy          <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state          <= CMD_WR;
                    cnt            <= req_len;
                    lcd_hw_cs      <= 1'b0;
                    lcd_hw_rs      <= LCD_CMD_INST;
                    lcd_hw_wr      <= 1'b0;
                    lcd_hw_data_o  <= req_cmd;
                    lcd_hw_data_oe <= 1'b1;
                end
                CMD_WR: if (done) begin
                    state     <= CMD_HOLD;
                    lcd_hw_wr <= 1'b1;
                end
                CMD_HOLD: if (done) begin
                    state          <= RD_LOW;
                    lcd_hw_rs      <= LCD_CMD_DATA;
                    lcd_hw_rd      <= 1'b0;
                    lcd_hw_data_oe <= 1'b0;
                    dummy          <= DUMMY;
                end
                RD_LOW: if (done) begin
                    state     <= RD_HIGH;
                    lcd_hw_rd <= 1'b1;
                    rsp_valid <= !dummy;
                    rsp_last  <= cnt == '0;
                    if (!dummy) rsp_data <= lcd_hw_data_i;
                end
                RD_HIGH: if (done) begin
                    if (rsp_valid && !rsp_ready) state <= RSP_WAIT;
                    else if (!dummy && cnt == '0) begin
                        state     <= IDLE;
                        lcd_hw_cs <= 1'b1;
                    end else begin
                        state     <= RD_LOW;
                        lcd_hw_rd <= 1'b0;
                        cnt       <= dummy ? cnt : cnt - 1'b1;
                        dummy     <= 1'b0;
                    end
                end
                RSP_WAIT: if (rsp_ready) begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        lcd_hw_cs <= 1'b1;
                    end else begin
                        state     <= RD_LOW;
                        lcd_hw_rd <= 1'b0;
                        cnt       <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SHALL have parameter T_WRL, default 2, WR low width in clk cycles (min 1).
REQ-002 SHALL have parameter T_WRH, default 2, WR high/hold width in clk cycles (min 1).
REQ-003 SHALL have parameter T_RDL, default 12, RD low width in clk cycles (min 2).
REQ-004 SHALL have parameter T_RDH, default 4, RD high width between reads in clk cycles (min 1).
REQ-005 SHALL have ports:
  clk  in  1  system clock, 33MHz
  resetn  in  1  asynchronous, active-low reset
  req_valid  in  1  read request
  req_ready  out  1  request accepted when both high
  req_cmd  in  16  register/command word sent before reading
  req_len  in  4  number of data words minus one (1..16 words)
  rsp_valid  out  1  read word available
  rsp_ready  in  1  consumer accepts word
  rsp_data  out  16  sampled word
  rsp_last  out  1  final word of request
  busy  out  1  transaction in progress
  lcd_hw_cs  out  1  chip select, active low
  lcd_hw_rs  out  1  0 = command, 1 = data
  lcd_hw_wr  out  1  write strobe, active low
  lcd_hw_rd  out  1  read strobe, active low
  lcd_hw_data_o  out  16  bus drive value
  lcd_hw_data_oe  out  1  1 = drive bus
  lcd_hw_data_i  in  16  bus sample value

Function
REQ-006 SHALL implement states IDLE, CMD_WR, CMD_HOLD, RD_LOW, RD_HIGH, RSP_WAIT.
REQ-007 SHALL assert req_ready only in IDLE; on req_valid&req_ready, latch req_cmd, latch req_len into word counter, go to CMD_WR.
REQ-008 CMD_WR: cs=0, rs=0, wr=0, rd=1, data_o=latched cmd, oe=1, for exactly T_WRL cycles; then CMD_HOLD.
REQ-009 CMD_HOLD: wr=1, rs=0, oe=1, data held, for T_WRH cycles; then RD_LOW with oe=0 from the first RD_LOW cycle.
REQ-010 RD_LOW: cs=0, rs=1, rd=0, oe=0, for T_RDL cycles; lcd_hw_data_i SHALL be registered on the clock edge ending the last RD_LOW cycle.
REQ-011 RD_HIGH: rd=1 for T_RDH cycles; a sampled data word SHALL assert rsp_valid with rsp_data from the first RD_HIGH cycle.
REQ-012 rsp_valid SHALL stay high, rsp_data/rsp_last stable, until rsp_ready; if not accepted by end of RD_HIGH, enter RSP_WAIT (rd=1, cs=0) until accepted.
REQ-013 After acceptance: if word counter == 0 go to IDLE (cs=1) with rsp_last having been 1; else decrement counter, go to RD_LOW.
REQ-014 rsp_valid&rsp_ready in same cycle as rsp_valid rises SHALL complete the handshake with no added cycle.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 lcd_hw_rd and lcd_hw_wr SHALL never be low in the same cycle; oe SHALL be 0 whenever rd=0.
REQ-017 Phase counters SHALL be wide enough for max(T_*); req_len=15 SHALL yield 16 words without wrap error.
REQ-018 All LCD outputs SHALL be registered (glitch-free).

Reset
REQ-019 On resetn=0, asynchronously: state IDLE, cs=1, rs=1, wr=1, rd=1, oe=0, data_o=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, req_ready=0 while resetn low, 1 in first cycle after release.
REQ-020 Reset mid-transaction SHALL abort immediately; no response word issued for the aborted request.

Configuration
REQ-021 With LCD_RD_DUMMY_EN defined, first RD_LOW/RD_HIGH cycle pair after CMD_HOLD SHALL be a dummy read: data discarded, no rsp_valid, word count unchanged.
REQ-022 Without LCD_RD_DUMMY_EN, first read after CMD_HOLD SHALL be returned as a data word.

Structure
REQ-023 Package lcd_pkg SHALL hold state enum, LCD_CMD_INST/LCD_CMD_DATA constants, default timing constants.
REQ-024 Single sub-module lcd_phase_timer (loadable down-counter, done pulse) SHALL time all phases.

Verification
REQ-025 req_cmd=16'h0004, req_len=3, rsp_ready=1, no macro -> one WR pulse of 2 cycles with data 0004/rs=0, four RD pulses of 12 cycles, 4 rsp words, rsp_last on 4th.
REQ-026 Same with LCD_RD_DUMMY_EN -> five RD pulses, four responses, first sampled value discarded.
REQ-027 Bus model returns 16'hA5C3 -> rsp_data=16'hA5C3 in first RD_HIGH cycle.
REQ-028 rsp_ready held low 20 cycles after word 1 -> RSP_WAIT, rd=1, no further RD pulse until accepted.
REQ-029 resetn asserted during RD_LOW of word 2 -> same-cycle cs=1, rd=1, oe=0, busy=0, no rsp_valid.
REQ-030 req_valid during busy -> req_ready=0, request held, accepted in first IDLE cycle.
